// File: rtl/full_adder_pkg.sv
// Shared constants for the full_adder block.
package full_adder_pkg;

    // Default operand/result width of the adder.
    localparam int FA_WIDTH = 30;

endpackage

// File: rtl/full_adder_if.sv
// Operand/result bundle for full_adder.
//
// Handshake: the master presents a, b and add_one_en together with
// in_valid=1; each rising edge with in_valid=1 is one accepted operation.
// There is no ready/backpressure. One cycle later the slave raises
// out_valid for exactly one cycle while sum/cout carry that result; at all
// other times sum/cout hold the last result (or zero after reset).
interface full_adder_if
    import full_adder_pkg::*;
#(
    parameter int WIDTH = FA_WIDTH
);

    logic             in_valid;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             add_one_en;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             out_valid;

    // Producer of operands / consumer of results.
    modport master (
        output in_valid, a, b, add_one_en,
        input  sum, cout, out_valid
    );

    // The adder itself.
    modport slave (
        input  in_valid, a, b, add_one_en,
        output sum, cout, out_valid
    );

endinterface

// File: rtl/full_adder_mux2to1.sv
// One-bit 2:1 multiplexer, purely combinational: OUT = IN[SEL].
module mux2to1 (
    input  logic [1:0] IN,
    input  logic       SEL,
    output logic       OUT
);

    // Select one of the two inputs.
    always_comb begin
        OUT = IN[SEL];
    end

endmodule

// File: rtl/full_adder.sv
// Registered ripple-carry adder: {cout,sum} = a + b + add_one_en, one cycle
// after an in_valid sample. Only the output registers hold state.
module full_adder
    import full_adder_pkg::*;
#(
    parameter int WIDTH = FA_WIDTH
) (
    input  logic       clk,
    input  logic       rst_n,
    full_adder_if.slave bus
);

    logic             carry_in;
    logic [WIDTH-1:0] sum_bits;
    logic             carry_out;

    logic [WIDTH-1:0] sum_d, sum_q;
    logic             cout_d, cout_q;
    logic             out_valid_d, out_valid_q;

    // Carry-in selects constant 0 or 1 depending on add_one_en.
    mux2to1 u_cin_mux (
        .IN  ({1'b1, 1'b0}),
        .SEL (bus.add_one_en),
        .OUT (carry_in)
    );

    // Ripple chain: each cell keeps its own carry wire so the chain is a
    // set of distinct nets rather than one self-referencing vector.
    for (genvar j = 0; j < WIDTH; j++) begin : g_cell
        logic c_in;
        logic c_out;

        if (j == 0) begin : g_first
            assign c_in = carry_in;
        end else begin : g_rest
            assign c_in = g_cell[j-1].c_out;
        end

        assign sum_bits[j] = bus.a[j] ^ bus.b[j] ^ c_in;
        assign c_out       = (bus.a[j] & bus.b[j]) | (c_in & (bus.a[j] ^ bus.b[j]));
    end

    assign carry_out = g_cell[WIDTH-1].c_out;

    // Capture a new result on in_valid, otherwise hold and drop out_valid.
    always_comb begin
        sum_d       = sum_q;
        cout_d      = cout_q;
        out_valid_d = 1'b0;
        if (bus.in_valid) begin
            sum_d       = sum_bits;
            cout_d      = carry_out;
            out_valid_d = 1'b1;
        end
    end

    // Output registers; reset clears them immediately, discarding any result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_q       <= '0;
            cout_q      <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            sum_q       <= sum_d;
            cout_q      <= cout_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign bus.sum       = sum_q;
    assign bus.cout      = cout_q;
    assign bus.out_valid = out_valid_q;

endmodule

// File: tb/tb_full_adder.sv
// Self-checking bench for full_adder: directed cases, reset cases and a
// randomized stream compared against an arithmetic reference model.
module tb_full_adder;
    import full_adder_pkg::*;

    localparam int WIDTH = FA_WIDTH;

    logic clk;
    logic rst_n;

    int n_checks;
    int n_errors;

    // Expected {cout,sum} values for accepted operations, oldest first.
    logic [WIDTH:0] exp_q[$];
    // Value the outputs must show (held between results).
    logic [WIDTH:0] exp_hold;

    full_adder_if #(.WIDTH(WIDTH)) bus ();

    full_adder #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Clock: 10 ns period, rising edges at 5, 15, 25 ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference: exact unsigned sum of the operands and the carry-in.
    function automatic logic [WIDTH:0] model_add(input logic [WIDTH-1:0] av,
                                                 input logic [WIDTH-1:0] bv,
                                                 input logic             c);
        logic [WIDTH:0] wide_a;
        logic [WIDTH:0] wide_b;
        logic [WIDTH:0] wide_c;
        wide_a = {1'b0, av};
        wide_b = {1'b0, bv};
        wide_c = '0;
        wide_c[0] = c;
        return wide_a + wide_b + wide_c;
    endfunction

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t",
                     tag, got, got, exp, exp, $time);
        end
    endtask

    task automatic check_outputs(input string tag, input logic exp_valid);
        check_val({tag, "_valid"}, 64'(bus.out_valid), 64'(exp_valid));
        check_val({tag, "_sum"},   64'(bus.sum),       64'(exp_hold[WIDTH-1:0]));
        check_val({tag, "_cout"},  64'(bus.cout),      64'(exp_hold[WIDTH]));
    endtask

    // Drive one cycle of inputs at the falling edge, then check just after
    // the following rising edge.
    task automatic step(input logic v, input logic [WIDTH-1:0] av,
                        input logic [WIDTH-1:0] bv, input logic c, input string tag);
        @(negedge clk);
        bus.in_valid   = v;
        bus.a          = av;
        bus.b          = bv;
        bus.add_one_en = c;
        if (v) exp_q.push_back(model_add(av, bv, c));
        @(posedge clk);
        #1;
        if (v) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL %s_scoreboard: expected queue empty", tag);
            end else begin
                exp_hold = exp_q.pop_front();
            end
        end
        check_outputs(tag, v);
    endtask

    function automatic logic [WIDTH-1:0] rand_operand();
        logic [63:0] r;
        r = {$urandom(), $urandom()};
        case ($urandom_range(0, 7))
            0:       return '1;
            1:       return '0;
            default: return r[WIDTH-1:0];
        endcase
    endfunction

    initial begin
        logic [WIDTH-1:0] all_ones;
        logic [WIDTH-1:0] half;
        logic [WIDTH-1:0] held_sum;

        n_checks = 0;
        n_errors = 0;
        exp_hold = '0;
        all_ones = '1;
        half     = '0;
        half[WIDTH-1] = 1'b1;

        rst_n          = 1'b0;
        bus.in_valid   = 1'b0;
        bus.a          = '0;
        bus.b          = '0;
        bus.add_one_en = 1'b0;

        // Reset state, before any clock edge.
        #3;
        check_outputs("reset_init", 1'b0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed cases.
        step(1'b1, WIDTH'(1234), '0, 1'b0, "a1234_cin0");
        check_val("a1234_cin0_lit", 64'(bus.sum), 64'd1234);
        step(1'b1, WIDTH'(1234), '0, 1'b1, "a1234_cin1");
        check_val("a1234_cin1_lit", 64'(bus.sum), 64'd1235);
        step(1'b1, WIDTH'(83648), WIDTH'(1), 1'b0, "b2b_first");
        check_val("b2b_first_lit", 64'(bus.sum), 64'd83649);
        step(1'b1, WIDTH'(214748), WIDTH'(248), 1'b0, "b2b_second");
        check_val("b2b_second_lit", 64'(bus.sum), 64'd214996);
        step(1'b1, all_ones, '0, 1'b1, "wrap_ones");
        check_val("wrap_ones_lit", 64'({bus.cout, bus.sum}), 64'(1) << WIDTH);
        step(1'b1, half, half, 1'b0, "wrap_half");
        check_val("wrap_half_lit", 64'({bus.cout, bus.sum}), 64'(1) << WIDTH);
        step(1'b1, all_ones, all_ones, 1'b1, "max_sum");

        // Idle cycles: outputs hold, out_valid low.
        step(1'b1, WIDTH'(777), WIDTH'(5), 1'b0, "pre_idle");
        held_sum = bus.sum;
        for (int i = 0; i < 3; i++) begin
            step(1'b0, rand_operand(), rand_operand(), 1'(i), "idle");
        end
        check_val("idle_hold_lit", 64'(bus.sum), 64'd782);

        // Reset between edges with an operation pending.
        @(negedge clk);
        bus.in_valid   = 1'b1;
        bus.a          = WIDTH'(4321);
        bus.b          = WIDTH'(99);
        bus.add_one_en = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        exp_hold = '0;
        exp_q.delete();
        check_outputs("reset_async", 1'b0);
        @(negedge clk);
        bus.in_valid = 1'b0;
        rst_n = 1'b1;
        check_outputs("reset_held", 1'b0);
        for (int i = 0; i < 2; i++) begin
            step(1'b0, '0, '0, 1'b0, "post_reset");
        end

        // Randomized stream with mixed idle and back-to-back operations.
        for (int i = 0; i < 300; i++) begin
            step(($urandom_range(0, 3) != 0), rand_operand(), rand_operand(),
                 1'($urandom_range(0, 1)), "rand");
        end

        if (exp_q.size() != 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL scoreboard_drain: %0d results never seen", exp_q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/full_adder.md
FULL_ADDER -- requirements
Module: full_adder

Interface
REQ-001 Parameter WIDTH, default 30, operand/result bit width (legal range 2..64).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 in_valid  input  1  high = a, b, add_one_en are valid this cycle.
REQ-005 a  input  WIDTH  operand A, unsigned.
REQ-006 b  input  WIDTH  operand B, unsigned.
REQ-007 add_one_en  input  1  high = carry-in of 1 (A+B+1); low = carry-in of 0 (A+B).
REQ-008 sum  output  WIDTH  registered result, modulo 2^WIDTH.
REQ-009 cout  output  1  registered carry out of the MSB.
REQ-010 out_valid  output  1  high for one cycle when sum/cout hold a new result.

Function
REQ-011 Carry-in SHALL be produced by a 2:1 mux: SEL=add_one_en, IN[0]=1'b0, IN[1]=1'b1, OUT=IN[SEL].
REQ-012 Addition SHALL be a ripple-carry chain of WIDTH one-bit full-adder cells: SUM=A^B^Cin, Cout=(A&B)|(Cin&(A^B)).
REQ-013 Bit 0 cell SHALL take the mux output as Cin; bit j (j>=1) SHALL take carry of bit j-1; MSB carry SHALL drive cout.
REQ-014 {cout,sum} SHALL equal a + b + add_one_en, exact to WIDTH+1 bits.
REQ-015 Latency SHALL be one cycle: inputs sampled at edge N with in_valid=1 appear on sum/cout with out_valid=1 after edge N.
REQ-016 When in_valid=0 at an edge, sum/cout SHALL hold previous values and out_valid SHALL be 0.
REQ-017 Back-to-back in_valid=1 SHALL yield one result per cycle; no stall, no backpressure.
REQ-018 Wrap-around: all-ones + 0 with add_one_en=1 SHALL give sum=0, cout=1.
REQ-019 X/Z on add_one_en is illegal input; the bench SHALL always drive it.

Reset
REQ-020 rst_n low SHALL immediately (without clock) force sum=0, cout=0, out_valid=0.
REQ-021 Reset asserted mid-stream SHALL discard the in-flight result; first out_valid after release requires a new in_valid sample.
REQ-022 No combinational path from rst_n to anything other than the output registers.

Structure
REQ-023 Shared package SHALL hold the default WIDTH constant (30) and nothing else.
REQ-024 The one-bit mux SHALL be sub-module mux2to1 (IN[1:0], SEL, OUT), purely combinational.
REQ-025 The one-bit cell SHALL be a generate-loop of combinational full-adder cells inside full_adder; only output registers are sequential.

Verification
REQ-026 a=1234, b=0, add_one_en=0, in_valid=1 -> next cycle sum=1234, cout=0, out_valid=1.
REQ-027 a=1234, b=0, add_one_en=1 -> sum=1235, cout=0.
REQ-028 a=83648, b=1, add_one_en=0 -> sum=83649; then a=214748, b=248 on next cycle -> sum=214996 one cycle later (back-to-back).
REQ-029 a=2^30-1, b=0, add_one_en=1 -> sum=0, cout=1; a=2^29, b=2^29 -> sum=0, cout=1.
REQ-030 in_valid=0 for 3 cycles after a result -> sum unchanged, out_valid=0.
REQ-031 rst_n pulled low between clock edges with in_valid=1 pending -> sum=0, cout=0, out_valid=0 immediately; no stale result after release.
